// File: rtl/ycr_serial_debug_sched_pkg.sv
// ycr_serial_debug_sched shared definitions.
// Holds the scheduler FSM encoding, frame header layout and a header-packing helper.
package ycr_serial_debug_pkg;

    // Frame header: [7:4] source ID, [3:0] sequence; the payload sits above it.
    localparam int HDR_WD  = 8;
    localparam int ID_WD   = 4;
    localparam int SEQ_WD  = 4;

    localparam int SEQ_LSB = 0;
    localparam int ID_LSB  = SEQ_LSB + SEQ_WD;
    localparam int PLD_LSB = ID_LSB + ID_WD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    function automatic logic [HDR_WD-1:0] mk_hdr(
        input logic [ID_WD-1:0]  id,
        input logic [SEQ_WD-1:0] seq
    );
        return {id, seq};
    endfunction

endpackage

// File: rtl/ycr_serial_debug_sched_if.sv
// Bus bundle between the debug taps / shifter side and the frame scheduler.
// Carries config (cfg_*), source requests/acks (src_*), frame handshake (frm_*) and busy.
interface ycr_serial_debug_sched_if #(
    parameter int DEBUG_WD = 64,
    parameter int NSRC     = 4
);
    localparam int PLD_WD = DEBUG_WD - 8;

    logic                   cfg_en;
    logic [NSRC-1:0]        cfg_mask;
    logic [7:0]             cfg_gap;
    logic [NSRC-1:0]        src_valid;
    logic [NSRC*PLD_WD-1:0] src_data;
    logic [NSRC-1:0]        src_ack;
    logic                   frm_valid;
    logic [DEBUG_WD-1:0]    frm_data;
    logic                   frm_ready;
    logic                   busy;

    // master: taps, shifter and configuration side
    modport master (
        output cfg_en,
        output cfg_mask,
        output cfg_gap,
        output src_valid,
        output src_data,
        output frm_ready,
        input  src_ack,
        input  frm_valid,
        input  frm_data,
        input  busy
    );

    // slave: the scheduler itself
    modport slave (
        input  cfg_en,
        input  cfg_mask,
        input  cfg_gap,
        input  src_valid,
        input  src_data,
        input  frm_ready,
        output src_ack,
        output frm_valid,
        output frm_data,
        output busy
    );

endinterface

// File: rtl/ycr_serial_debug_sched_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
// Ports: req (requests), ptr (start index) -> gnt (one-hot), gnt_idx (binary).
module ycr_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_k;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_sum   = '0;
        w_k     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            // candidate index ptr+i folded back into 0..N-1
            w_sum = {1'b0, ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_k = w_sum[IW-1:0];
            if (!w_found && req[w_k]) begin
                w_found  = 1'b1;
                gnt[w_k] = 1'b1;
                gnt_idx  = w_k;
            end
        end
    end

endmodule

// File: rtl/ycr_serial_debug_sched.sv
// Round-robin frame scheduler sharing one serial debug shifter among NSRC sources.
// Ports: clk, reset (async, active-high), dbg (slave bundle: cfg_*, src_*, frm_*, busy).
module ycr_serial_debug_sched
    import ycr_serial_debug_pkg::*;
#(
    parameter int DEBUG_WD = 64,
    parameter int NSRC     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    ycr_serial_debug_sched_if.slave dbg
);

    localparam int PLD_WD = DEBUG_WD - HDR_WD;
    localparam int IW     = (NSRC > 1) ? $clog2(NSRC) : 1;

    sched_state_e        r_state;
    sched_state_e        w_state_nxt;
    logic [IW-1:0]       r_ptr;
    logic [SEQ_WD-1:0]   r_seq;
    logic [7:0]          r_gap_cnt;
    logic [DEBUG_WD-1:0] r_frm;

    logic [NSRC-1:0]     w_req;
    logic [NSRC-1:0]     w_gnt;
    logic [IW-1:0]       w_gnt_idx;
    logic [IW-1:0]       w_ptr_nxt;
    logic [PLD_WD-1:0]   w_pld;
    logic [ID_WD-1:0]    w_id;
    logic                w_any;
    logic                w_load;
    logic                w_accept;

    assign w_req    = dbg.src_valid & dbg.cfg_mask;
    assign w_any    = |w_req;
    assign w_load   = (r_state == ST_GRANT) && w_any;
    assign w_accept = (r_state == ST_SEND) && dbg.frm_ready;

    ycr_rr_arbiter #(
        .N  (NSRC),
        .IW (IW)
    ) u_arb (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_pld     = dbg.src_data[w_gnt_idx*PLD_WD +: PLD_WD];
    assign w_id      = ID_WD'(w_gnt_idx);
    assign w_ptr_nxt = (w_gnt_idx == IW'(NSRC-1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // cfg_en only gates leaving IDLE, so a frame already granted always completes
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (dbg.cfg_en && w_any) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_state_nxt = w_any ? ST_SEND : ST_IDLE;
            end
            ST_SEND: begin
                if (dbg.frm_ready) begin
                    w_state_nxt = (dbg.cfg_gap != 8'd0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dbg.src_ack   = '0;
        dbg.frm_valid = 1'b0;
        dbg.busy      = 1'b0;
        unique case (r_state)
            ST_GRANT: begin
                dbg.src_ack = w_gnt;
                dbg.busy    = 1'b1;
            end
            ST_SEND: begin
                dbg.frm_valid = 1'b1;
                dbg.busy      = 1'b1;
            end
            ST_GAP: begin
                dbg.busy = 1'b1;
            end
            default: begin
                dbg.busy = 1'b0;
            end
        endcase
    end

    assign dbg.frm_data = r_frm;

    // Frame register and round-robin pointer move only on a real grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frm <= '0;
            r_ptr <= '0;
        end else if (w_load) begin
            r_frm <= {w_pld, mk_hdr(w_id, r_seq)};
            r_ptr <= w_ptr_nxt;
        end
    end

    // seq advances per accepted frame; gap counter loads on accept and drains in GAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq     <= '0;
            r_gap_cnt <= '0;
        end else if (w_accept) begin
            r_seq     <= r_seq + 1'b1;
            r_gap_cnt <= dbg.cfg_gap;
        end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_ycr_serial_debug_sched.sv
// Self-checking bench for ycr_serial_debug_sched (NSRC=4, DEBUG_WD=64).
// A transaction-level model predicts grants and frames; directed tests pin timing.
module tb_ycr_serial_debug_sched;

    localparam int DEBUG_WD = 64;
    localparam int NSRC     = 4;
    localparam int PLD_WD   = DEBUG_WD - 8;
    localparam logic [PLD_WD-1:0] PAT_A5 = {7{8'hA5}};
    localparam logic [PLD_WD-1:0] PAT_B  = 56'h0123456789ABCD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ycr_serial_debug_sched_if #(.DEBUG_WD(DEBUG_WD), .NSRC(NSRC)) dif ();

    ycr_serial_debug_sched #(
        .DEBUG_WD (DEBUG_WD),
        .NSRC     (NSRC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (dif)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // model state
    int                  m_ptr = 0;
    int                  m_acc = 0;
    logic [DEBUG_WD-1:0] m_exp_q[$];
    logic                m_prev_valid = 0;
    logic                m_prev_acc = 0;
    logic                m_prev_ack = 0;
    logic [DEBUG_WD-1:0] m_prev_data = '0;
    logic [NSRC-1:0]     ack_seen = '0;
    logic                drop_on_ack = 1'b1;

    // observation logs for directed tests
    int                  ack_log[$];
    int                  ack_cyc[$];
    int                  acc_cyc[$];
    logic [DEBUG_WD-1:0] acc_frm[$];

    logic [NSRC-1:0]     mon_req;
    logic [NSRC-1:0]     mon_one;
    logic [DEBUG_WD-1:0] mon_exp;
    logic                mon_acc;
    int                  mon_g;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NSRC-1:0] req, input int ptr);
        int k;
        for (int i = 0; i < NSRC; i++) begin
            k = (ptr + i) % NSRC;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        ack_seen = '0;
        if (reset) begin
            chk("rst_valid", 64'(dif.frm_valid), 0);
            chk("rst_ack", 64'(dif.src_ack), 0);
            chk("rst_busy", 64'(dif.busy), 0);
            chk("rst_data", dif.frm_data, 0);
            m_ptr = 0;
            m_acc = 0;
            m_exp_q.delete();
            m_prev_valid = 0;
            m_prev_acc = 0;
            m_prev_ack = 0;
        end else begin
            mon_req = dif.src_valid & dif.cfg_mask;
            if (m_prev_acc) chk("valid_drop", 64'(dif.frm_valid), 0);
            if (m_prev_ack) chk("valid_after_ack", 64'(dif.frm_valid), 1);
            if (dif.src_ack != 0) begin
                mon_g = rr_pick(mon_req, m_ptr);
                mon_one = '0;
                if (mon_g >= 0) mon_one[mon_g] = 1'b1;
                chk("ack_rr", 64'(dif.src_ack), 64'(mon_one));
                if (mon_g >= 0) begin
                    mon_exp = {dif.src_data[mon_g*PLD_WD +: PLD_WD],
                               4'(mon_g), 4'(m_acc)};
                    m_exp_q.push_back(mon_exp);
                    m_ptr = (mon_g + 1) % NSRC;
                    ack_log.push_back(mon_g);
                    ack_cyc.push_back(cyc);
                end
                ack_seen = dif.src_ack;
            end
            if (dif.frm_valid && m_prev_valid && !m_prev_acc)
                chk("hold_stable", dif.frm_data, m_prev_data);
            if (dif.frm_valid || dif.src_ack != 0)
                chk("busy", 64'(dif.busy), 1);
            mon_acc = dif.frm_valid && dif.frm_ready;
            if (mon_acc) begin
                if (m_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame: got %h required no frame", dif.frm_data);
                end else begin
                    chk("frame", dif.frm_data, m_exp_q.pop_front());
                end
                m_acc++;
                acc_cyc.push_back(cyc);
                acc_frm.push_back(dif.frm_data);
            end
            m_prev_valid = dif.frm_valid;
            m_prev_data = dif.frm_data;
            m_prev_acc = mon_acc;
            m_prev_ack = (dif.src_ack != 0);
        end
    end

    // one cycle step; sources acked last cycle refresh payload and may withdraw
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++) begin
            if (ack_seen[i]) begin
                if (drop_on_ack) dif.src_valid[i] = 1'b0;
                dif.src_data[i*PLD_WD +: PLD_WD] = PLD_WD'({$urandom, $urandom});
            end
        end
    endtask

    task automatic clear_logs();
        ack_log.delete();
        ack_cyc.delete();
        acc_cyc.delete();
        acc_frm.delete();
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (acc_cyc.size() < n) begin
            errors++;
            $display("FAIL wait_acc: got %0d frames required %0d", acc_cyc.size(), n);
        end
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!dif.frm_valid && k < budget) begin
            tick();
            k++;
        end
        chk("wait_valid", 64'(dif.frm_valid), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (dif.busy && k < budget) begin
            tick();
            k++;
        end
        chk("wait_idle", 64'(dif.busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [DEBUG_WD-1:0] f;
    logic [DEBUG_WD-1:0] d0;
    int c0;

    initial begin
        reset = 1'b1;
        dif.cfg_en = 1'b0;
        dif.cfg_mask = '0;
        dif.cfg_gap = '0;
        dif.src_valid = '0;
        dif.src_data = '0;
        dif.frm_ready = 1'b0;
        do_reset();

        // single source, ready tied high
        dif.cfg_en = 1'b1;
        dif.cfg_mask = 4'hF;
        dif.cfg_gap = 8'd0;
        dif.frm_ready = 1'b1;
        drop_on_ack = 1'b1;
        repeat (5) tick();
        clear_logs();
        c0 = cyc;
        dif.src_data[2*PLD_WD +: PLD_WD] = PAT_A5;
        dif.src_valid[2] = 1'b1;
        tick();
        chk("t1_ack_now", 64'(dif.src_ack), 64'(4'b0100));
        wait_acc(1, 20);
        if (ack_log.size() > 0) begin
            chk("t1_ack_id", ack_log[0], 2);
            chk("t1_ack_lat", ack_cyc[0] - c0, 1);
        end
        if (acc_frm.size() > 0) begin
            f = acc_frm[0];
            chk("t1_valid_lat", acc_cyc[0] - c0, 2);
            chk("t1_hdr", 64'(f[7:0]), 64'h20);
            chk("t1_pld", 64'(f[63:8]), 64'(PAT_A5));
        end
        repeat (3) tick();
        chk("t1_single_ack", ack_log.size(), 1);

        // round robin over all four sources, seq wraps on 17th frame
        do_reset();
        drop_on_ack = 1'b0;
        dif.src_valid = 4'hF;
        wait_acc(17, 200);
        for (int k = 0; k < 17; k++) begin
            if (k < ack_log.size() && k < acc_frm.size()) begin
                f = acc_frm[k];
                chk("t2_ack_order", ack_log[k], k % 4);
                chk("t2_id", 64'(f[7:4]), k % 4);
                chk("t2_seq", 64'(f[3:0]), k % 16);
                if (k > 0) chk("t2_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
            end
        end
        dif.src_valid = '0;
        wait_idle(20);

        // backpressure: ready low 20 cycles while in SEND
        clear_logs();
        drop_on_ack = 1'b1;
        dif.frm_ready = 1'b0;
        dif.src_data[1*PLD_WD +: PLD_WD] = PAT_B;
        dif.src_valid = 4'b0010;
        wait_valid(10);
        d0 = dif.frm_data;
        repeat (20) tick();
        chk("t3_still_valid", 64'(dif.frm_valid), 1);
        chk("t3_held", dif.frm_data, d0);
        chk("t3_no_accept", acc_cyc.size(), 0);
        dif.frm_ready = 1'b1;
        repeat (5) tick();
        chk("t3_acks", ack_log.size(), 1);
        chk("t3_frames", acc_frm.size(), 1);
        if (acc_frm.size() > 0) begin
            f = acc_frm[0];
            chk("t3_frame", f, d0);
            chk("t3_id", 64'(f[7:4]), 1);
            chk("t3_pld", 64'(f[63:8]), 64'(PAT_B));
        end

        // mask and gap: only sources 1 and 3, spacing 3 + gap
        clear_logs();
        drop_on_ack = 1'b0;
        dif.cfg_mask = 4'b1010;
        dif.cfg_gap = 8'd5;
        dif.src_valid = 4'hF;
        wait_acc(5, 200);
        for (int k = 0; k < 5; k++) begin
            if (k < ack_log.size() && k < acc_cyc.size()) begin
                chk("t4_masked", 64'(ack_log[k] == 1 || ack_log[k] == 3), 1);
                if (k > 0) begin
                    chk("t4_alternate", ack_log[k], (ack_log[k-1] == 1) ? 3 : 1);
                    chk("t4_spacing", acc_cyc[k] - acc_cyc[k-1], 3 + 5);
                end
            end
        end
        dif.src_valid = '0;
        wait_idle(30);
        dif.cfg_gap = 8'd0;
        dif.cfg_mask = 4'hF;

        // disable during SEND: frame completes, no more grants
        clear_logs();
        drop_on_ack = 1'b1;
        dif.frm_ready = 1'b0;
        dif.src_valid = 4'b0100;
        wait_valid(10);
        dif.cfg_en = 1'b0;
        dif.src_valid = 4'b1011;
        repeat (2) tick();
        dif.frm_ready = 1'b1;
        repeat (10) tick();
        chk("t5_one_frame", acc_frm.size(), 1);
        chk("t5_one_ack", ack_log.size(), 1);
        chk("t5_idle", 64'(dif.busy), 0);
        if (acc_frm.size() > 0) begin
            f = acc_frm[0];
            chk("t5_id", 64'(f[7:4]), 2);
        end

        // reset mid-SEND: outputs clear at once, restart from source 0
        clear_logs();
        dif.frm_ready = 1'b0;
        dif.src_valid = 4'b1010;
        dif.cfg_en = 1'b1;
        wait_valid(10);
        if (ack_log.size() > 0) chk("t6_pre_id", ack_log[0], 3);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(dif.frm_valid), 0);
        chk("t6_rst_busy", 64'(dif.busy), 0);
        chk("t6_rst_data", dif.frm_data, 0);
        tick();
        tick();
        clear_logs();
        dif.src_valid = 4'b1010;
        dif.frm_ready = 1'b1;
        reset = 1'b0;
        wait_acc(1, 20);
        if (ack_log.size() > 0) chk("t6_first_id", ack_log[0], 1);
        if (acc_frm.size() > 0) begin
            f = acc_frm[0];
            chk("t6_hdr_id", 64'(f[7:4]), 1);
            chk("t6_hdr_seq", 64'(f[3:0]), 0);
        end
        dif.src_valid = '0;
        wait_idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
